lcd_frame_sched: RTL and testbench

- Triple-buffer bank scheduler for the LCD frame buffer.
- Sits between the PPU pixel write stream (clk_sys) and the video scan-out reader, and decides which bank the writer fills and which bank the reader displays.
- Produces tear-free swaps: completed frames are promoted to "ready", short frames are discarded, and frames are dropped or repeated when write and read rates differ.
- Exports statistics counters for the OSD/debug.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_sat_cnt.sv | 39 +++
 rtl/lcd_frame_sched.sv | 193 +++++++++++++++++++
 tb/tb_lcd_frame_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD frame-buffer scheduler:
//   LCD_W / LCD_H / FRAME_PIX : Game Boy screen geometry and pixel count.
//   PIX_W                     : width of the per-frame pixel counter.
//   bank_t                    : frame-buffer bank id (0..2).
//   third_bank()              : the bank that is neither a nor b.
// ----------------------------------------------------------------------------
package lcd_pkg;

   localparam int LCD_W     = 160;
   localparam int LCD_H     = 144;
   localparam int FRAME_PIX = LCD_W * LCD_H;
   localparam int PIX_W     = 15;

   typedef logic [1:0] bank_t;

   localparam bank_t BANK_WR_RST    = 2'd0;
   localparam bank_t BANK_RD_RST    = 2'd1;
   localparam bank_t BANK_READY_RST = 2'd2;

   // With a != b drawn from {0,1,2}, 3-a-b is the remaining id.
   // Modulo-4 wrap of the 2-bit subtraction still lands on it.
   function automatic bank_t third_bank(input bank_t a, input bank_t b);
      return bank_t'(2'd3 - a - b);
   endfunction

endpackage

// File: rtl/lcd_sat_cnt.sv
// ----------------------------------------------------------------------------
// lcd_sat_cnt
// Saturating up-counter used for the scheduler statistics. It sticks at
// all-ones and never wraps.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (clears the count)
//   inc_i   : count one event this cycle
//   value_o : current count
// ----------------------------------------------------------------------------
module lcd_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] value_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/lcd_frame_sched.sv
// ----------------------------------------------------------------------------
// lcd_frame_sched
// Triple-buffer bank scheduler between the PPU pixel writer and the video
// scan-out reader. Complete frames are promoted to "ready", short or aborted
// frames are discarded, and frames are dropped/repeated on rate mismatch.
// Ports:
//   clk_sys        : system clock
//   reset_n        : asynchronous active-low reset
//   tri_buf        : 1 = triple buffering, 0 = single bank 0
//   wr_pix         : pixel write strobe
//   wr_frame_end   : writer finished a frame
//   wr_frame_abort : LCD switched off mid-frame
//   rd_frame_start : reader begins a new frame
//   wr_en          : frame RAM write enable
//   wr_addr        : {write bank, pixel index}
//   rd_bank        : bank the reader scans
//   frame_ready    : a completed frame is waiting
//   overrun        : sticky, a pixel arrived with the frame already full
//   drop_cnt       : ready frames overwritten before display
//   repeat_cnt     : reader starts with no new frame
//   short_cnt      : frames discarded as incomplete or aborted
// ----------------------------------------------------------------------------
module lcd_frame_sched
   import lcd_pkg::*;
#(
   parameter int FRAME_PIX = lcd_pkg::FRAME_PIX,
   parameter int CNT_W     = 8
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             tri_buf,
   input  logic             wr_pix,
   input  logic             wr_frame_end,
   input  logic             wr_frame_abort,
   input  logic             rd_frame_start,
   output logic             wr_en,
   output logic [16:0]      wr_addr,
   output logic [1:0]       rd_bank,
   output logic             frame_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] repeat_cnt,
   output logic [CNT_W-1:0] short_cnt
);

   localparam logic [PIX_W-1:0] FULL_CNT = PIX_W'(FRAME_PIX);

   bank_t            wr_bank_q, wr_bank_d;
   bank_t            rd_bank_q, rd_bank_d;
   bank_t            ready_bank_q, ready_bank_d;
   logic             frame_ready_q, frame_ready_d;
   logic             overrun_q, overrun_d;
   logic [PIX_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             tri_q;

   logic             pix_room;
   logic             wr_en_int;
   logic [PIX_W:0]   eff_cnt;
   logic             complete;
   logic             tri_edge;
   logic             discard;
   logic             end_ok;
   logic             drop_inc, repeat_inc, short_inc;
   bank_t            wr_bank_out;

   assign pix_room  = (wr_cnt_q < FULL_CNT);
   assign wr_en_int = wr_pix & pix_room;

   // A pixel written in the same cycle as the end pulse belongs to the
   // ending frame, so completeness is judged on the post-increment count.
   assign eff_cnt   = {1'b0, wr_cnt_q} + {{PIX_W{1'b0}}, wr_en_int};
   assign complete  = (eff_cnt == {1'b0, FULL_CNT});

   assign tri_edge  = tri_buf ^ tri_q;
   assign discard   = wr_frame_abort | (wr_frame_end & ~complete);
   assign end_ok    = wr_frame_end & ~wr_frame_abort & complete;

   always_comb begin
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      ready_bank_d  = ready_bank_q;
      frame_ready_d = frame_ready_q;
      overrun_d     = overrun_q;
      wr_cnt_d      = wr_cnt_q;
      drop_inc      = 1'b0;
      repeat_inc    = 1'b0;
      short_inc     = 1'b0;

      if (wr_en_int) begin
         wr_cnt_d = wr_cnt_q + PIX_W'(1);
      end
      if (wr_pix && !pix_room) begin
         overrun_d = 1'b1;
      end

      if (tri_edge) begin
         // Mode change: restart from the reset bank arrangement and silently
         // throw away whatever frame was being written.
         wr_bank_d     = BANK_WR_RST;
         rd_bank_d     = BANK_RD_RST;
         ready_bank_d  = BANK_READY_RST;
         frame_ready_d = 1'b0;
         wr_cnt_d      = '0;
      end else begin
         if (discard) begin
            wr_cnt_d  = '0;
            short_inc = 1'b1;
         end else if (end_ok) begin
            wr_cnt_d  = '0;
         end

         // Bank rotation only exists in triple-buffer mode; in single-bank
         // mode the banks stay where the last mode change put them.
         if (tri_buf) begin
            if (end_ok && rd_frame_start) begin
               // Reader takes the frame that just finished; the previously
               // displayed bank becomes the spare.
               rd_bank_d     = wr_bank_q;
               wr_bank_d     = third_bank(wr_bank_q, rd_bank_q);
               ready_bank_d  = rd_bank_q;
               frame_ready_d = 1'b0;
               drop_inc      = frame_ready_q;
            end else if (end_ok) begin
               ready_bank_d  = wr_bank_q;
               wr_bank_d     = third_bank(wr_bank_q, rd_bank_q);
               frame_ready_d = 1'b1;
               drop_inc      = frame_ready_q;
            end else if (rd_frame_start) begin
               if (frame_ready_q) begin
                  rd_bank_d     = ready_bank_q;
                  ready_bank_d  = rd_bank_q;
                  frame_ready_d = 1'b0;
               end else begin
                  repeat_inc = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_q     <= BANK_WR_RST;
         rd_bank_q     <= BANK_RD_RST;
         ready_bank_q  <= BANK_READY_RST;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         wr_cnt_q      <= '0;
         // Triple buffering is the expected power-up mode; starting in
         // single-bank mode only costs a harmless restart on the first cycle.
         tri_q         <= 1'b1;
      end else begin
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         ready_bank_q  <= ready_bank_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         wr_cnt_q      <= wr_cnt_d;
         tri_q         <= tri_buf;
      end
   end

   lcd_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .inc_i   (drop_inc),
      .value_o (drop_cnt)
   );

   lcd_sat_cnt #(.CNT_W(CNT_W)) u_repeat_cnt (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .inc_i   (repeat_inc),
      .value_o (repeat_cnt)
   );

   lcd_sat_cnt #(.CNT_W(CNT_W)) u_short_cnt (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .inc_i   (short_inc),
      .value_o (short_cnt)
   );

   // Single-bank mode is applied at the outputs so it takes effect in the
   // same cycle tri_buf drops, before the registered mode change lands.
   assign wr_bank_out = tri_buf ? wr_bank_q : BANK_WR_RST;
   assign rd_bank     = tri_buf ? rd_bank_q : BANK_WR_RST;
   assign frame_ready = frame_ready_q & tri_buf;
   assign overrun     = overrun_q;
   assign wr_en       = wr_en_int;
   assign wr_addr     = {wr_bank_out, wr_cnt_q};

endmodule

// File: tb/tb_lcd_frame_sched.sv
`timescale 1ns/1ps
module tb_lcd_frame_sched;

   localparam int CNT_W = 8;
   localparam int FP    = 23040;

   logic             clk_sys = 1'b0;
   logic             reset_n;
   logic             tri_buf;
   logic             wr_pix;
   logic             wr_frame_end;
   logic             wr_frame_abort;
   logic             rd_frame_start;
   logic             wr_en;
   logic [16:0]      wr_addr;
   logic [1:0]       rd_bank;
   logic             frame_ready;
   logic             overrun;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] repeat_cnt;
   logic [CNT_W-1:0] short_cnt;

   int checks   = 0;
   int failures = 0;

   // Scoreboard of frame-RAM writes the bench expects, in order.
   logic [16:0] exp_q[$];

   always #5 clk_sys = ~clk_sys;

   lcd_frame_sched #(.FRAME_PIX(FP), .CNT_W(CNT_W)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .tri_buf        (tri_buf),
      .wr_pix         (wr_pix),
      .wr_frame_end   (wr_frame_end),
      .wr_frame_abort (wr_frame_abort),
      .rd_frame_start (rd_frame_start),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .rd_bank        (rd_bank),
      .frame_ready    (frame_ready),
      .overrun        (overrun),
      .drop_cnt       (drop_cnt),
      .repeat_cnt     (repeat_cnt),
      .short_cnt      (short_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic pix_burst(input int n, input int bank, input int start);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({bank[1:0], 15'(start + i)});
         wr_pix = 1'b1;
         tick();
      end
      wr_pix = 1'b0;
   endtask

   task automatic pulse(input logic e, input logic a, input logic r);
      wr_frame_end   = e;
      wr_frame_abort = a;
      rd_frame_start = r;
      tick();
      wr_frame_end   = 1'b0;
      wr_frame_abort = 1'b0;
      rd_frame_start = 1'b0;
   endtask

   // Write monitor and bank-separation watch, sampled on the falling edge.
   always @(negedge clk_sys) begin
      if (reset_n === 1'b1) begin
         if (wr_en === 1'b1) begin
            chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
         end
         if (tri_buf === 1'b1) chk("bank_sep", 32'(wr_addr[16:15] != rd_bank), 32'd1);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n        = 1'b0;
      tri_buf        = 1'b1;
      wr_pix         = 1'b0;
      wr_frame_end   = 1'b0;
      wr_frame_abort = 1'b0;
      rd_frame_start = 1'b0;

      // Reset state
      repeat (2) @(negedge clk_sys);
      chk("rst_wr_en",   32'(wr_en),       32'd0);
      chk("rst_wr_addr", 32'(wr_addr),     32'h0);
      chk("rst_rd_bank", 32'(rd_bank),     32'd1);
      chk("rst_ready",   32'(frame_ready), 32'd0);
      chk("rst_overrun", 32'(overrun),     32'd0);
      chk("rst_drop",    32'(drop_cnt),    32'd0);
      chk("rst_repeat",  32'(repeat_cnt),  32'd0);
      chk("rst_short",   32'(short_cnt),   32'd0);
      tick();
      reset_n = 1'b1;

      // First complete frame into bank 0; last address is {0, 23039}
      pix_burst(FP, 0, 0);
      chk("f1_queue", 32'(exp_q.size()), 32'd0);
      pulse(1'b1, 1'b0, 1'b0);
      chk("f1_ready",   32'(frame_ready), 32'd1);
      chk("f1_wr_addr", 32'(wr_addr),     32'h10000);
      chk("f1_rd_bank", 32'(rd_bank),     32'd1);
      chk("f1_drop",    32'(drop_cnt),    32'd0);

      // Second frame into bank 2, one extra pixel overruns, then end -> drop
      pix_burst(FP, 2, 0);
      wr_pix = 1'b1;
      @(negedge clk_sys);
      chk("ovr_wr_en",   32'(wr_en),   32'd0);
      chk("ovr_wr_addr", 32'(wr_addr), 32'h15A00);
      tick();
      wr_pix = 1'b0;
      chk("ovr_sticky", 32'(overrun), 32'd1);
      pulse(1'b1, 1'b0, 1'b0);
      chk("f2_drop",    32'(drop_cnt),    32'd1);
      chk("f2_ready",   32'(frame_ready), 32'd1);
      chk("f2_wr_addr", 32'(wr_addr),     32'h0);
      chk("f2_rd_bank", 32'(rd_bank),     32'd1);
      chk("f2_overrun", 32'(overrun),     32'd1);

      // Reader takes the ready frame (bank 2), then repeats
      pulse(1'b0, 1'b0, 1'b1);
      chk("rd1_bank",   32'(rd_bank),     32'd2);
      chk("rd1_ready",  32'(frame_ready), 32'd0);
      chk("rd1_repeat", 32'(repeat_cnt),  32'd0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("rd2_repeat", 32'(repeat_cnt),  32'd1);
      chk("rd2_bank",   32'(rd_bank),     32'd2);

      // Short frames: abort, end+abort, incomplete end with reader start
      pix_burst(1000, 0, 0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("abort_short",   32'(short_cnt),   32'd1);
      chk("abort_wr_addr", 32'(wr_addr),     32'h0);
      chk("abort_ready",   32'(frame_ready), 32'd0);
      pix_burst(1000, 0, 0);
      pulse(1'b1, 1'b1, 1'b0);
      chk("endab_short",   32'(short_cnt),   32'd2);
      chk("endab_wr_addr", 32'(wr_addr),     32'h0);
      pix_burst(1000, 0, 0);
      pulse(1'b1, 1'b0, 1'b1);
      chk("inc_short",  32'(short_cnt),  32'd3);
      chk("inc_repeat", 32'(repeat_cnt), 32'd2);
      chk("inc_rd",     32'(rd_bank),    32'd2);

      // Single-bank mode entered mid-frame
      pix_burst(500, 0, 0);
      tri_buf = 1'b0;
      tick();
      chk("sb_wr_addr", 32'(wr_addr),     32'h0);
      chk("sb_rd_bank", 32'(rd_bank),     32'd0);
      chk("sb_ready",   32'(frame_ready), 32'd0);
      chk("sb_short",   32'(short_cnt),   32'd3);
      pix_burst(5, 0, 0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("sb_repeat_frozen", 32'(repeat_cnt), 32'd2);
      chk("sb_rd_fixed",      32'(rd_bank),    32'd0);
      pulse(1'b1, 1'b0, 1'b0);
      chk("sb_short_inc", 32'(short_cnt), 32'd4);
      tri_buf = 1'b1;
      tick();
      chk("tb_wr_addr", 32'(wr_addr),     32'h0);
      chk("tb_rd_bank", 32'(rd_bank),     32'd1);
      chk("tb_ready",   32'(frame_ready), 32'd0);
      chk("tb_short",   32'(short_cnt),   32'd4);

      // Complete end (last pixel in the same cycle) together with reader start
      pix_burst(FP - 1, 0, 0);
      exp_q.push_back({2'd0, 15'(FP - 1)});
      wr_pix = 1'b1;
      pulse(1'b1, 1'b0, 1'b1);
      wr_pix = 1'b0;
      chk("joint_rd",     32'(rd_bank),     32'd0);
      chk("joint_wr",     32'(wr_addr),     32'h10000);
      chk("joint_ready",  32'(frame_ready), 32'd0);
      chk("joint_drop",   32'(drop_cnt),    32'd1);
      chk("joint_repeat", 32'(repeat_cnt),  32'd2);
      chk("joint_queue",  32'(exp_q.size()), 32'd0);

      // repeat_cnt saturates at 255
      rd_frame_start = 1'b1;
      repeat (260) tick();
      rd_frame_start = 1'b0;
      chk("sat_repeat", 32'(repeat_cnt), 32'd255);
      chk("sat_rd",     32'(rd_bank),    32'd0);

      // Asynchronous reset mid-frame
      pix_burst(3, 2, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_wr_en",   32'(wr_en),       32'd0);
      chk("arst_wr_addr", 32'(wr_addr),     32'h0);
      chk("arst_rd_bank", 32'(rd_bank),     32'd1);
      chk("arst_ready",   32'(frame_ready), 32'd0);
      chk("arst_overrun", 32'(overrun),     32'd0);
      chk("arst_drop",    32'(drop_cnt),    32'd0);
      chk("arst_repeat",  32'(repeat_cnt),  32'd0);
      chk("arst_short",   32'(short_cnt),   32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rd_bank", 32'(rd_bank), 32'd1);
      chk("final_queue",  32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
